// File: rtl/seven_segment_pkg.sv
// Shared constants for the 7-segment scanner: segment slot indices,
// the hex-to-segment decode table ({g..a}), and the scan state encoding.
package seven_segment_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Entry i is the active-high pattern for hex digit i; entry 0 sits in the low 7 bits.
    localparam logic [15:0][6:0] HEX_TO_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        SCAN_DEAD,
        SCAN_DRIVE
    } scan_state_t;

endpackage

// File: rtl/seven_segment_hex_decoder.sv
// Combinational hex nibble to active-high segment pattern {g,f,e,d,c,b,a}.
module seven_segment_hex_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = HEX_TO_SEG[nibble];
    end

endmodule

// File: rtl/seven_segment_display_scanner.sv
// Time-multiplexed 7-segment driver with a dead cycle between digits.
// Optional build macro SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
//
// state      | meaning
// SCAN_DEAD  | one cycle, all digits off, displayed word refreshed from value register
// SCAN_DRIVE | digit at index_q lit until prescaler wraps
module seven_segment_display_scanner
    import seven_segment_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b0,
    localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_value,
    input  logic                  display_enable,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_select,
    output logic [IDX_W-1:0]      digit_index
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{ACTIVE_LOW}};

    scan_state_t           state_q, state_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [4*DIGITS-1:0]   shown_q, shown_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     sel_q, sel_d;

    logic                  tick;
    logic [3:0]            nibble;
    logic [DIGITS-1:0]     onehot;
    logic                  blank;
    logic [6:0]            dec_seg;

    always_comb begin
        nibble = 4'h0;
        onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (index_q == IDX_W'(k)) begin
                nibble    = shown_q[4*k +: 4];
                onehot[k] = 1'b1;
            end
        end
    end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        upper_zero = 1'b1;
        blank      = 1'b0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && (shown_q[4*k +: 4] == 4'h0);
            if ((index_q == IDX_W'(k)) && upper_zero) begin
                blank = 1'b1;
            end
        end
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    seven_segment_hex_decoder u_decoder (
        .nibble   (nibble),
        .segments (dec_seg)
    );

    always_comb begin
        tick     = (pre_q == PRE_W'(REFRESH_DIV - 1));
        pre_d    = tick ? '0 : pre_q + PRE_W'(1);
        value_d  = load ? hex_value : value_q;
        shown_d  = shown_q;
        state_d  = state_q;
        index_d  = index_q;
        seg_d    = SEG_OFF;
        sel_d    = SEL_OFF;

        // Displayed word only changes while dark, so a DRIVE window never tears.
        if (state_q == SCAN_DEAD) begin
            shown_d = value_d;
        end

        case (state_q)
            SCAN_DEAD: begin
                state_d = SCAN_DRIVE;
            end
            SCAN_DRIVE: begin
                if (tick) begin
                    state_d = SCAN_DEAD;
                    index_d = (index_q == IDX_W'(DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = SCAN_DEAD;
            end
        endcase

        if ((state_q == SCAN_DRIVE) && display_enable) begin
            sel_d = ACTIVE_LOW ? ~onehot : onehot;
            seg_d = blank ? SEG_OFF : (ACTIVE_LOW ? ~dec_seg : dec_seg);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SCAN_DEAD;
            pre_q   <= '0;
            index_q <= '0;
            value_q <= '0;
            shown_q <= '0;
            seg_q   <= SEG_OFF;
            sel_q   <= SEL_OFF;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            index_q <= index_d;
            value_q <= value_d;
            shown_q <= shown_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign segments     = seg_q;
    assign digit_select = sel_q;
    assign digit_index  = index_q;

endmodule
